// File: rtl/disp_pkg.sv
// Shared definitions for the display SPI bus arbiters.
package disp_pkg;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StGap   = 2'd3
  } arb_state_e;

  // Values driven onto the SPI pins while no engine owns the bus.
  localparam logic MOSI_IDLE = 1'b0;
  localparam logic DC_IDLE   = 1'b0;
  localparam logic CS_IDLE   = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping mod N.
module rr_pick #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit after ptr_i wins.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    for (int k = int'(N); k >= 1; k--) begin
      cand = IW'((int'(ptr_i) + k) % int'(N));
      if (req_i[cand]) idx_o = cand;
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the display SPI pins shared by the drawing engines.
module spi_bus_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned GAP     = 4,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned IW     = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mosi,
  input  logic [N-1:0]  i_dc,
  input  logic [N-1:0]  i_cs,
  input  logic [N-1:0]  i_done,
  output logic [N-1:0]  o_start,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_busy,
  output logic          o_timeout,
  output logic          o_mosi,
  output logic          o_dc,
  output logic          o_cs
);

  localparam logic [31:0] TimeoutLast = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic [31:0] GapLast     = (GAP == 0) ? 32'd0 : 32'(GAP - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  start_q, start_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   gap_q, gap_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  // Next-state: arbitrate in idle, pulse start, hold grant until done or watchdog, then guard gap.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    start_d   = '0;
    timeout_d = 1'b0;
    wd_d      = wd_q;
    gap_d     = gap_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          ptr_d   = pick_idx;
          idx_d   = pick_idx;
          grant_d = pick_oh;
          start_d = pick_oh;
          state_d = StStart;
        end
      end
      StStart: begin
        // Done is deliberately not sampled here; the engine has only just been started.
        wd_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        if (i_done[idx_q]) begin
          grant_d = '0;
          gap_d   = '0;
          state_d = (GAP == 0) ? StIdle : StGap;
        end else if ((TIMEOUT != 0) && (wd_q == TimeoutLast)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          gap_d     = '0;
          state_d   = (GAP == 0) ? StIdle : StGap;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 32'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; pointer starts at N-1 so requester 0 is favoured first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      ptr_q     <= IW'(N - 1);
      idx_q     <= '0;
      grant_q   <= '0;
      start_q   <= '0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
    end
  end

  // Pin mux from the registered grant, so reset forces cs high without waiting for a clock.
  always_comb begin
    o_mosi = MOSI_IDLE;
    o_dc   = DC_IDLE;
    o_cs   = CS_IDLE;
    if ((grant_q != '0) && ((state_q == StStart) || (state_q == StRun))) begin
      o_mosi = i_mosi[idx_q];
      o_dc   = i_dc[idx_q];
      o_cs   = i_cs[idx_q];
    end
  end

  assign o_start   = start_q;
  assign o_grant   = grant_q;
  assign o_idx     = idx_q;
  assign o_busy    = (state_q != StIdle);
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench: u_dut has no watchdog, u_wd has TIMEOUT=50; both N=3, GAP=4.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, done, req_w, done_w;
  logic [2:0] mosi, dc, cs;

  logic [2:0] start, grant;
  logic [1:0] idx;
  logic       busy, tmo, bmosi, bdc, bcs;

  logic [2:0] w_start, w_grant;
  logic [1:0] w_idx;
  logic       w_busy, w_tmo, w_mosi, w_dc, w_cs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.N(3), .GAP(4), .TIMEOUT(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_mosi(mosi), .i_dc(dc), .i_cs(cs),
    .i_done(done), .o_start(start), .o_grant(grant), .o_idx(idx), .o_busy(busy),
    .o_timeout(tmo), .o_mosi(bmosi), .o_dc(bdc), .o_cs(bcs)
  );

  spi_bus_arbiter #(.N(3), .GAP(4), .TIMEOUT(50)) u_wd (
    .i_clk(clk), .i_rst(rst), .i_req(req_w), .i_mosi(mosi), .i_dc(dc), .i_cs(cs),
    .i_done(done_w), .o_start(w_start), .o_grant(w_grant), .o_idx(w_idx), .o_busy(w_busy),
    .o_timeout(w_tmo), .o_mosi(w_mosi), .o_dc(w_dc), .o_cs(w_cs)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; done = '0; req_w = '0; done_w = '0;
    mosi = '0; dc = '0; cs = 3'b111;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  // Wait (bounded) for a start pulse on u_dut, check it, run, then pulse done.
  task automatic serve(input logic [2:0] exp, input logic [1:0] exp_idx, input int run,
                       output int waited);
    waited = 0;
    while (start == 3'b000 && waited < 20) begin tick; waited++; end
    checks++;
    if ({start, grant, idx} !== {exp, exp, exp_idx}) begin
      errors++;
      $display("FAIL serve_grant: start/grant/idx got %b/%b/%0d want %b/%b/%0d",
               start, grant, idx, exp, exp, exp_idx);
    end
    repeat (run) tick;
    done = exp; tick; done = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; done = '0; req_w = '0; done_w = '0;
    mosi = 3'b111; dc = 3'b111; cs = 3'b000;
    #3;
    checks++;
    if ({start, grant, idx, busy, tmo, bmosi, bdc, bcs} !== 13'b000_000_00_0_0_0_0_1) begin
      errors++;
      $display("FAIL reset_main: got %b want 0000000000001",
               {start, grant, idx, busy, tmo, bmosi, bdc, bcs});
    end
    checks++;
    if ({w_start, w_grant, w_idx, w_busy, w_tmo, w_mosi, w_dc, w_cs} !== 13'b0000000000001) begin
      errors++;
      $display("FAIL reset_wd: got %b want 0000000000001",
               {w_start, w_grant, w_idx, w_busy, w_tmo, w_mosi, w_dc, w_cs});
    end
    tick; rst = 1'b0; tick; tick;
    checks++;
    if ({start, grant, busy, bcs} !== 8'b000_000_0_1) begin
      errors++;
      $display("FAIL reset_idle_noreq: got %b want 00000001", {start, grant, busy, bcs});
    end
  endtask

  task automatic test_single;
    do_reset;
    mosi = 3'b001; dc = 3'b001; cs = 3'b110; req = 3'b001;
    tick;
    checks++;
    if ({start, grant, idx, busy} !== {3'b001, 3'b001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL t1_start: got %b want 001001001", {start, grant, idx, busy});
    end
    checks++;
    if ({bmosi, bdc, bcs} !== 3'b110) begin
      errors++;
      $display("FAIL t1_bus_start: got %b want 110", {bmosi, bdc, bcs});
    end
    tick;
    checks++;
    if ({start, grant} !== 6'b000_001) begin
      errors++;
      $display("FAIL t1_run: start/grant got %b/%b want 000/001", start, grant);
    end
    req = '0; mosi = 3'b000; dc = 3'b000;
    #1;
    checks++;
    if ({bmosi, bdc, bcs, grant} !== 6'b000_001) begin
      errors++;
      $display("FAIL t1_bus_follow: bus/grant got %b want 000001", {bmosi, bdc, bcs, grant});
    end
    repeat (98) tick;
    done = 3'b001; tick; done = '0;
    checks++;
    if ({grant, busy, bcs} !== 5'b000_1_1) begin
      errors++;
      $display("FAIL t1_released: grant/busy/cs got %b want 00011", {grant, busy, bcs});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({busy, bcs, start} !== 5'b1_1_000) begin
        errors++;
        $display("FAIL t1_gap%0d: busy/cs/start got %b want 11000", i, {busy, bcs, start});
      end
    end
    tick;
    checks++;
    if ({busy, grant, bcs} !== 5'b0_000_1) begin
      errors++;
      $display("FAIL t1_idle: busy/grant/cs got %b want 00001", {busy, grant, bcs});
    end
  endtask

  task automatic test_two_req;
    int w;
    do_reset;
    req = 3'b101;
    serve(3'b001, 2'd0, 20, w);
    serve(3'b100, 2'd2, 20, w);
    serve(3'b001, 2'd0, 20, w);
    serve(3'b100, 2'd2, 20, w);
    req = '0;
  endtask

  task automatic test_back_to_back;
    int w;
    int exp_w;
    logic [2:0] oh;
    do_reset;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      oh = 3'b001 << (k % 3);
      serve(oh, 2'(k % 3), 5, w);
      exp_w = (k == 0) ? 1 : 5;
      checks++;
      if (w !== exp_w) begin
        errors++;
        $display("FAIL b2b_turnaround%0d: waited %0d cycles want %0d", k, w, exp_w);
      end
    end
    req = '0;
  endtask

  task automatic test_watchdog;
    int n;
    do_reset;
    req_w = 3'b100;
    tick;
    checks++;
    if ({w_start, w_grant, w_idx} !== {3'b100, 3'b100, 2'd2}) begin
      errors++;
      $display("FAIL t4_start: got %b want 10010010", {w_start, w_grant, w_idx});
    end
    req_w = 3'b101;
    repeat (50) tick;
    checks++;
    if ({w_tmo, w_grant} !== 4'b0_100) begin
      errors++;
      $display("FAIL t4_run50: tmo/grant got %b want 0100", {w_tmo, w_grant});
    end
    tick;
    checks++;
    if ({w_tmo, w_grant, w_busy, w_cs} !== 6'b1_000_1_1) begin
      errors++;
      $display("FAIL t4_pulse: tmo/grant/busy/cs got %b want 100011",
               {w_tmo, w_grant, w_busy, w_cs});
    end
    tick;
    checks++;
    if (w_tmo !== 1'b0) begin
      errors++;
      $display("FAIL t4_one_cycle: tmo got %b want 0", w_tmo);
    end
    n = 0;
    while (w_start == 3'b000 && n < 20) begin tick; n++; end
    checks++;
    if ({w_start, w_grant, w_idx} !== {3'b001, 3'b001, 2'd0}) begin
      errors++;
      $display("FAIL t4_next: got %b want 00100100", {w_start, w_grant, w_idx});
    end
    req_w = '0;
    repeat (50) tick;
    done_w = 3'b001; tick; done_w = '0;
    checks++;
    if ({w_tmo, w_grant} !== 4'b0_000) begin
      errors++;
      $display("FAIL t4_done_wins: tmo/grant got %b want 0000", {w_tmo, w_grant});
    end
    tick;
    checks++;
    if (w_tmo !== 1'b0) begin
      errors++;
      $display("FAIL t4_no_late_tmo: tmo got %b want 0", w_tmo);
    end
  endtask

  task automatic test_ignore_and_reset;
    do_reset;
    mosi = 3'b001; dc = 3'b000; cs = 3'b110; req = 3'b001;
    tick;
    done = 3'b001; tick; done = '0;
    checks++;
    if ({grant, busy} !== 4'b001_1) begin
      errors++;
      $display("FAIL t5_done_in_start: grant/busy got %b want 0011", {grant, busy});
    end
    tick;
    done = 3'b010; tick; done = '0;
    checks++;
    if ({grant, busy, bcs, bmosi} !== 6'b001_1_0_1) begin
      errors++;
      $display("FAIL t5_foreign_done: grant/busy/cs/mosi got %b want 001101",
               {grant, busy, bcs, bmosi});
    end
    #2; rst = 1'b1; #1;
    checks++;
    if ({grant, start, busy, bcs, bmosi, bdc, idx} !== 13'b000_000_0_1_0_0_00) begin
      errors++;
      $display("FAIL t5_async_reset: got %b want 0000000100000",
               {grant, start, busy, bcs, bmosi, bdc, idx});
    end
    tick;
    rst = 1'b0; req = 3'b011;
    tick;
    checks++;
    if ({start, grant, idx} !== {3'b001, 3'b001, 2'd0}) begin
      errors++;
      $display("FAIL t5_after_reset: got %b want 00100100", {start, grant, idx});
    end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_two_req;
    test_back_to_back;
    test_watchdog;
    test_ignore_and_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
